// File: rtl/phase_corr_branch.sv
// Phase-corrector branch: y[n] = x[n] +/- x[n-DELAY] in signed Q(NB_DATA-1),
// saturated to NB_DATA. The delay line advances only on accepted samples, so
// the taps are DELAY samples apart, not DELAY cycles. A warm-up counter keeps
// o_valid low until the line holds DELAY real samples.
module phase_corr_branch #(
  parameter int NB_DATA = 16,
  parameter int DELAY   = 2    // legal range 1..64
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic signed [NB_DATA-1:0] i_data,
  input  logic                      i_valid,
  input  logic [1:0]                i_mode,
  input  logic                      i_clear,
  output logic signed [NB_DATA-1:0] o_data,
  output logic                      o_valid,
  output logic                      o_sat
);

  typedef enum logic [1:0] {
    MODE_SUM   = 2'b00,
    MODE_DIFF  = 2'b01,
    MODE_DELAY = 2'b10,
    MODE_ZERO  = 2'b11
  } mode_e;

  localparam int                       CNT_W    = $clog2(DELAY + 1);
  localparam logic [CNT_W-1:0]         CNT_FULL = CNT_W'(DELAY);
  localparam logic signed [NB_DATA-1:0] SAT_POS = {1'b0, {(NB_DATA-1){1'b1}}};
  localparam logic signed [NB_DATA-1:0] SAT_NEG = {1'b1, {(NB_DATA-1){1'b0}}};

  logic signed [NB_DATA-1:0] line_q [DELAY];
  logic [CNT_W-1:0]          warm_cnt_q;
  logic                      accept;
  mode_e                     mode;
  logic signed [NB_DATA-1:0] tail;
  logic signed [NB_DATA:0]   x_ext;
  logic signed [NB_DATA:0]   t_ext;
  logic signed [NB_DATA:0]   wide;
  logic signed [NB_DATA-1:0] res_d;
  logic                      sat_d;

  // A flush drops any sample presented alongside it.
  assign accept = i_valid & ~i_clear;
  assign mode   = mode_e'(i_mode);
  assign tail   = line_q[DELAY-1];

  // Combine x[n] with the line tail one bit wider, then clamp on overflow.
  always_comb begin
    // NOTE: every signal gets a default first so no path can leave it
    // unassigned, which would otherwise infer a latch.
    x_ext = {i_data[NB_DATA-1], i_data};
    t_ext = {tail[NB_DATA-1], tail};
    wide  = '0;
    res_d = '0;
    sat_d = 1'b0;
    case (mode)
      MODE_SUM, MODE_DIFF: begin
        wide = (mode == MODE_SUM) ? x_ext + t_ext : x_ext - t_ext;
        if (wide[NB_DATA] != wide[NB_DATA-1]) begin
          sat_d = 1'b1;
          res_d = wide[NB_DATA] ? SAT_NEG : SAT_POS;
        end else begin
          res_d = wide[NB_DATA-1:0];
        end
      end
      MODE_DELAY: res_d = tail;
      default:    res_d = '0;
    endcase
  end

  // Delay line, warm-up counter and registered outputs.
  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; the shift below relies on that ordering.
    if (i_rst || i_clear) begin
      // NOTE: the delay line is a register chain, not a RAM, because both
      // reset and flush must zero the history; a RAM could not be cleared
      // in one cycle.
      for (int k = 0; k < DELAY; k++) line_q[k] <= '0;
      warm_cnt_q <= '0;
      o_data     <= '0;
      o_valid    <= 1'b0;
      o_sat      <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      if (accept) begin
        line_q[0] <= i_data;
        for (int k = 1; k < DELAY; k++) line_q[k] <= line_q[k-1];
        if (warm_cnt_q != CNT_FULL) warm_cnt_q <= warm_cnt_q + 1'b1;
        o_data  <= res_d;
        o_sat   <= sat_d;
        o_valid <= (warm_cnt_q == CNT_FULL);
      end
    end
  end

endmodule

// File: tb/tb_phase_corr_branch.sv
// Self-checking bench: two instances (DELAY=2 and DELAY=5) share one input
// stream and are compared every cycle against a sample-history model, plus
// directed scenarios with hand-derived expected values.
module tb_phase_corr_branch;

  logic               i_clk = 1'b0;
  logic               i_rst;
  logic               i_valid;
  logic               i_clear;
  logic [1:0]         i_mode;
  logic signed [15:0] i_data;

  logic signed [15:0] o_data_a, o_data_b;
  logic               o_valid_a, o_valid_b;
  logic               o_sat_a, o_sat_b;

  int checks = 0;
  int errors = 0;

  // Reference model state: accepted-sample history since the last flush.
  int          dly [2] = '{2, 5};
  int          hist [2][0:4095];
  int          nacc [2];
  logic [15:0] exp_data [2];
  logic        exp_valid [2];
  logic        exp_sat [2];

  phase_corr_branch #(.NB_DATA(16), .DELAY(2)) dut_a (
    .i_clk(i_clk), .i_rst(i_rst), .i_data(i_data), .i_valid(i_valid),
    .i_mode(i_mode), .i_clear(i_clear),
    .o_data(o_data_a), .o_valid(o_valid_a), .o_sat(o_sat_a)
  );

  phase_corr_branch #(.NB_DATA(16), .DELAY(5)) dut_b (
    .i_clk(i_clk), .i_rst(i_rst), .i_data(i_data), .i_valid(i_valid),
    .i_mode(i_mode), .i_clear(i_clear),
    .o_data(o_data_b), .o_valid(o_valid_b), .o_sat(o_sat_b)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Apply one cycle of inputs, advance the model, compare both instances.
  task automatic cycle(input logic rst, input logic clr, input logic vld,
                       input logic [15:0] x, input logic [1:0] m);
    int xs, ts, r;
    logic        sat;
    logic [15:0] gd;
    logic        gv, gs;
    i_rst = rst; i_clear = clr; i_valid = vld; i_data = x; i_mode = m;
    @(posedge i_clk);
    for (int i = 0; i < 2; i++) begin
      if (rst || clr) begin
        nacc[i] = 0;
        exp_data[i] = '0; exp_valid[i] = 1'b0; exp_sat[i] = 1'b0;
      end else if (vld) begin
        xs = $signed(x);
        ts = (nacc[i] >= dly[i]) ? hist[i][nacc[i] - dly[i]] : 0;
        case (m)
          2'b00:   r = xs + ts;
          2'b01:   r = xs - ts;
          2'b10:   r = ts;
          default: r = 0;
        endcase
        sat = 1'b0;
        if (r > 32767)  begin r = 32767;  sat = 1'b1; end
        if (r < -32768) begin r = -32768; sat = 1'b1; end
        exp_data[i]  = r[15:0];
        exp_sat[i]   = sat;
        exp_valid[i] = (nacc[i] >= dly[i]);
        hist[i][nacc[i]] = xs;
        nacc[i]++;
      end else begin
        exp_valid[i] = 1'b0;
      end
    end
    #1;
    for (int i = 0; i < 2; i++) begin
      gd = (i == 0) ? o_data_a  : o_data_b;
      gv = (i == 0) ? o_valid_a : o_valid_b;
      gs = (i == 0) ? o_sat_a   : o_sat_b;
      check($sformatf("d%0d_valid", dly[i]), {31'd0, gv}, {31'd0, exp_valid[i]});
      check($sformatf("d%0d_data", dly[i]), {16'd0, gd}, {16'd0, exp_data[i]});
      check($sformatf("d%0d_sat", dly[i]), {31'd0, gs}, {31'd0, exp_sat[i]});
    end
  endtask

  task automatic accept(input logic [15:0] x, input logic [1:0] m);
    cycle(1'b0, 1'b0, 1'b1, x, m);
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 1'b0, 16'h5A5A, 2'b00);
  endtask

  task automatic flush();
    cycle(1'b0, 1'b1, 1'b0, 16'h0000, 2'b00);
  endtask

  initial begin
    logic [15:0] rx;
    logic        rv, rc, rr;
    i_rst = 1'b1; i_clear = 1'b0; i_valid = 1'b0; i_data = '0; i_mode = '0;
    for (int i = 0; i < 2; i++) nacc[i] = 0;

    // Reset state.
    cycle(1'b1, 1'b0, 1'b0, 16'h0000, 2'b00);
    cycle(1'b1, 1'b0, 1'b1, 16'h1111, 2'b00);
    check("rst_data", {16'd0, o_data_a}, 32'h0);
    check("rst_valid", {31'd0, o_valid_a}, 32'h0);

    // 1: warm-up then first qualified sum.
    accept(16'h1000, 2'b00);
    check("t1_first_valid", {31'd0, o_valid_a}, 32'h0);
    check("t1_first_data", {16'd0, o_data_a}, 32'h1000);
    accept(16'h2000, 2'b00);
    check("t1_second_valid", {31'd0, o_valid_a}, 32'h0);
    accept(16'h3000, 2'b00);
    check("t1_data", {16'd0, o_data_a}, 32'h4000);
    check("t1_valid", {31'd0, o_valid_a}, 32'h1);
    check("t1_sat", {31'd0, o_sat_a}, 32'h0);

    // 2: positive and negative saturation.
    accept(16'h7000, 2'b00);
    accept(16'h0000, 2'b00);
    accept(16'h7000, 2'b00);
    check("t2_pos_data", {16'd0, o_data_a}, 32'h7FFF);
    check("t2_pos_sat", {31'd0, o_sat_a}, 32'h1);
    accept(16'h7FFF, 2'b00);
    accept(16'h0000, 2'b00);
    accept(16'h8000, 2'b01);
    check("t2_neg_data", {16'd0, o_data_a}, 32'h8000);
    check("t2_neg_sat", {31'd0, o_sat_a}, 32'h1);
    idle();
    check("t2_hold_data", {16'd0, o_data_a}, 32'h8000);
    check("t2_hold_valid", {31'd0, o_valid_a}, 32'h0);

    // 3: gaps in i_valid do not age the line.
    flush();
    accept(16'h1000, 2'b00);
    idle();
    idle();
    accept(16'h2000, 2'b00);
    idle();
    accept(16'h3000, 2'b00);
    check("t3_data", {16'd0, o_data_a}, 32'h4000);
    check("t3_valid", {31'd0, o_valid_a}, 32'h1);

    // 4: flush wins over a simultaneous valid sample.
    accept(16'h0100, 2'b00);
    accept(16'h0200, 2'b00);
    cycle(1'b0, 1'b1, 1'b1, 16'h1234, 2'b00);
    check("t4_clr_data", {16'd0, o_data_a}, 32'h0);
    check("t4_clr_valid", {31'd0, o_valid_a}, 32'h0);
    accept(16'h0010, 2'b00);
    check("t4_after1_valid", {31'd0, o_valid_a}, 32'h0);
    accept(16'h0020, 2'b00);
    check("t4_after2_valid", {31'd0, o_valid_a}, 32'h0);
    accept(16'h0030, 2'b00);
    check("t4_after3_data", {16'd0, o_data_a}, 32'h0040);

    // 5: mode switch on consecutive accepts.
    flush();
    accept(16'h0800, 2'b00);
    accept(16'h0800, 2'b00);
    accept(16'h0800, 2'b00);
    check("t5_sum", {16'd0, o_data_a}, 32'h1000);
    accept(16'h0800, 2'b01);
    check("t5_diff", {16'd0, o_data_a}, 32'h0000);
    accept(16'h0800, 2'b10);
    check("t5_delay", {16'd0, o_data_a}, 32'h0800);
    accept(16'h0800, 2'b11);
    check("t5_zero", {16'd0, o_data_a}, 32'h0000);

    // 6: reset mid-stream on the DELAY=5 instance.
    for (int k = 0; k < 6; k++) accept(16'(16'h0100 * (k + 1)), 2'b00);
    cycle(1'b1, 1'b0, 1'b1, 16'h4444, 2'b00);
    check("t6_rst_data", {16'd0, o_data_b}, 32'h0);
    check("t6_rst_valid", {31'd0, o_valid_b}, 32'h0);
    for (int k = 0; k < 5; k++) begin
      accept(16'h0101, 2'b00);
      check($sformatf("t6_warm%0d_valid", k), {31'd0, o_valid_b}, 32'h0);
    end
    accept(16'h0202, 2'b00);
    check("t6_primed_valid", {31'd0, o_valid_b}, 32'h1);
    check("t6_primed_data", {16'd0, o_data_b}, 32'h0303);

    // Randomized stream against the model.
    for (int n = 0; n < 1500; n++) begin
      case ($urandom_range(0, 3))
        0:       rx = 16'(16'h7FFF - $urandom_range(0, 255));
        1:       rx = 16'(16'h8000 + $urandom_range(0, 255));
        default: rx = 16'($urandom);
      endcase
      rv = ($urandom_range(0, 9) < 6);
      rc = ($urandom_range(0, 99) < 2);
      rr = ($urandom_range(0, 199) < 1);
      cycle(rr, rc, rv, rx, 2'($urandom_range(0, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
